// File: rtl/output_port_arbiter.sv
// output_port_arbiter
//   Wormhole arbiter for one router output port. Grants one requesting input
//   at a time and holds the grant until that packet's tail flit has moved.
//   Tracks downstream buffer credits so a flit only moves when the next
//   router has a free slot. Round-robin priority advances when a packet
//   completes.
//
// Ports
//   CLK         in   1          clock, rising edge
//   RST         in   1          asynchronous active-high reset
//   REQ         in   N          input i has a head flit for this output
//   TAIL        in   N          input i's head flit is the last of its packet
//   CREDIT_IN   in   1          downstream freed one buffer slot (pulse)
//   GNT         out  N          one-hot grant to the owner, or zero
//   XFER        out  1          a flit moves this cycle
//   OWNER       out  clog2(N)   current owner index, valid while LOCKED
//   LOCKED      out  1          arbiter is in BUSY
//   CREDIT_CNT  out  CW         downstream credits available
//   ERR         out  1          sticky credit-overflow flag
//
// State | meaning
// IDLE  | no owner; round-robin scan of REQ from ptr picks the next owner
// BUSY  | owner holds the port until its tail flit transfers
module output_port_arbiter #(
  parameter int N       = 6,
  parameter int CREDITS = 4,
  parameter int CW      = $clog2(CREDITS + 1)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [N-1:0]         REQ,
  input  logic [N-1:0]         TAIL,
  input  logic                 CREDIT_IN,
  output logic [N-1:0]         GNT,
  output logic                 XFER,
  output logic [$clog2(N)-1:0] OWNER,
  output logic                 LOCKED,
  output logic [CW-1:0]        CREDIT_CNT,
  output logic                 ERR
);

  localparam int OW = $clog2(N);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [OW-1:0]   ptr_q, ptr_d;
  logic [OW-1:0]   owner_q, owner_d;
  logic [CW-1:0]   credit_cnt_q, credit_cnt_d;
  logic            err_q, err_d;

  logic            found;
  logic [OW-1:0]   winner;
  logic [OW-1:0]   cand;
  int              scan_idx;
  logic            xfer;
  logic [N-1:0]    gnt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      owner_q      <= '0;
      credit_cnt_q <= CW'(CREDITS);
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      owner_q      <= owner_d;
      credit_cnt_q <= credit_cnt_d;
      err_q        <= err_d;
    end
  end

  // Round-robin scan: first requester at ptr, ptr+1, ... (mod N).
  always_comb begin
    found    = 1'b0;
    winner   = '0;
    cand     = '0;
    scan_idx = 0;
    for (int i = 0; i < N; i++) begin
      scan_idx = (int'(ptr_q) + i) % N;
      cand     = OW'(scan_idx);
      if (!found && REQ[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // Credits gate only the transfer, never the arbitration.
  always_comb begin
    xfer = (state_q == BUSY) && REQ[owner_q] && (credit_cnt_q != '0);
    gnt  = '0;
    if (state_q == BUSY) gnt[owner_q] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          owner_d = winner;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (xfer && TAIL[owner_q]) begin
          ptr_d   = (owner_q == OW'(N - 1)) ? '0 : owner_q + OW'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A credit returned while the counter is already full means the
  // downstream buffer and this counter disagree; saturate and flag it.
  always_comb begin
    credit_cnt_d = credit_cnt_q;
    err_d        = err_q;
    case ({xfer, CREDIT_IN})
      2'b10: credit_cnt_d = credit_cnt_q - CW'(1);
      2'b01: begin
        if (credit_cnt_q == CW'(CREDITS)) err_d = 1'b1;
        else credit_cnt_d = credit_cnt_q + CW'(1);
      end
      default: credit_cnt_d = credit_cnt_q;
    endcase
  end

  assign GNT        = gnt;
  assign XFER       = xfer;
  assign OWNER      = owner_q;
  assign LOCKED     = (state_q == BUSY);
  assign CREDIT_CNT = credit_cnt_q;
  assign ERR        = err_q;

endmodule

// File: tb/tb_output_port_arbiter.sv
// Testbench for output_port_arbiter (N=6, CREDITS=4).
// Each step drives one cycle of inputs shortly after the rising edge and
// queues the hand-computed outputs for that cycle; the monitor pops and
// compares on the falling edge.
module tb_output_port_arbiter;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [5:0] REQ = '0;
  logic [5:0] TAIL = '0;
  logic       CREDIT_IN = 1'b0;
  logic [5:0] GNT;
  logic       XFER;
  logic [2:0] OWNER;
  logic       LOCKED;
  logic [2:0] CREDIT_CNT;
  logic       ERR;

  output_port_arbiter #(.N(6), .CREDITS(4)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .TAIL(TAIL), .CREDIT_IN(CREDIT_IN),
    .GNT(GNT), .XFER(XFER), .OWNER(OWNER), .LOCKED(LOCKED),
    .CREDIT_CNT(CREDIT_CNT), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int         step;
    logic [5:0] gnt;
    logic       xfer;
    logic [2:0] cnt;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int passes = 0;
  int step_no = 0;

  task automatic chk(input string name, input int s, input int act, input int expv);
    checks++;
    if (act == expv) passes++;
    else $display("FAIL %s step %0d: got %0h expected %0h", name, s, act, expv);
  endtask

  task automatic step(input logic rst, input logic [5:0] req, input logic [5:0] tail,
                      input logic cin, input logic [5:0] egnt, input logic exfer,
                      input logic [2:0] ecnt, input logic eerr);
    exp_t e;
    @(posedge CLK);
    #1;
    RST = rst; REQ = req; TAIL = tail; CREDIT_IN = cin;
    step_no++;
    e.step = step_no; e.gnt = egnt; e.xfer = exfer; e.cnt = ecnt; e.err = eerr;
    exp_q.push_back(e);
  endtask

  // Monitor
  initial begin
    exp_t e;
    int eo;
    forever begin
      @(negedge CLK);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("gnt",        e.step, int'(GNT),        int'(e.gnt));
        chk("xfer",       e.step, int'(XFER),       int'(e.xfer));
        chk("locked",     e.step, int'(LOCKED),     int'(|e.gnt));
        chk("credit_cnt", e.step, int'(CREDIT_CNT), int'(e.cnt));
        chk("err",        e.step, int'(ERR),        int'(e.err));
        if (e.gnt != '0) begin
          eo = 0;
          for (int b = 0; b < 6; b++) if (e.gnt[b]) eo = b;
          chk("owner", e.step, int'(OWNER), eo);
        end
      end
    end
  end

  initial begin
    logic [5:0] g;
    // Reset held with all inputs requesting
    step(1, 6'h3F, 6'h00, 0, 6'h00, 0, 4, 0);
    step(1, 6'h3F, 6'h00, 0, 6'h00, 0, 4, 0);

    // Round robin: single-flit packets, credit returned on each transfer
    for (int k = 0; k < 7; k++) begin
      g = 6'h01 << (k % 6);
      step(0, 6'h3F, 6'h3F, 0, 6'h00, 0, 4, 0);
      step(0, 6'h3F, 6'h3F, 1, g,     1, 4, 0);
    end

    // Wormhole hold: input 2 three flits, input 4 waiting (ptr = 1)
    step(0, 6'b010100, 6'b000000, 0, 6'h00, 0, 4, 0);
    step(0, 6'b010100, 6'b000000, 0, 6'h04, 1, 4, 0);
    step(0, 6'b010100, 6'b000000, 0, 6'h04, 1, 3, 0);
    step(0, 6'b010100, 6'b000100, 0, 6'h04, 1, 2, 0);
    step(0, 6'b010000, 6'b000000, 0, 6'h00, 0, 1, 0);
    step(0, 6'b010000, 6'b010000, 0, 6'h10, 1, 1, 0);
    // Refill credits while idle
    step(0, 6'h00, 6'h00, 1, 6'h00, 0, 0, 0);
    step(0, 6'h00, 6'h00, 1, 6'h00, 0, 1, 0);
    step(0, 6'h00, 6'h00, 1, 6'h00, 0, 2, 0);
    step(0, 6'h00, 6'h00, 1, 6'h00, 0, 3, 0);

    // Credit stall: 6-flit packet from input 1 (ptr = 5)
    step(0, 6'h02, 6'h00, 0, 6'h00, 0, 4, 0);
    step(0, 6'h02, 6'h00, 0, 6'h02, 1, 4, 0);
    step(0, 6'h02, 6'h00, 0, 6'h02, 1, 3, 0);
    step(0, 6'h02, 6'h00, 0, 6'h02, 1, 2, 0);
    step(0, 6'h02, 6'h00, 0, 6'h02, 1, 1, 0);
    step(0, 6'h02, 6'h00, 1, 6'h02, 0, 0, 0);
    step(0, 6'h02, 6'h00, 0, 6'h02, 1, 1, 0);
    step(0, 6'h02, 6'h00, 1, 6'h02, 0, 0, 0);
    step(0, 6'h02, 6'h02, 0, 6'h02, 1, 1, 0);
    step(0, 6'h00, 6'h00, 1, 6'h00, 0, 0, 0);
    step(0, 6'h00, 6'h00, 1, 6'h00, 0, 1, 0);
    step(0, 6'h00, 6'h00, 1, 6'h00, 0, 2, 0);
    step(0, 6'h00, 6'h00, 1, 6'h00, 0, 3, 0);

    // Overflow: credit returned while full and no transfer
    step(0, 6'h00, 6'h00, 1, 6'h00, 0, 4, 0);
    step(0, 6'h00, 6'h00, 0, 6'h00, 0, 4, 1);
    step(0, 6'h00, 6'h00, 0, 6'h00, 0, 4, 1);

    // Reset mid-packet: 4-flit packet from input 3 (ptr = 2)
    step(0, 6'h08, 6'h00, 0, 6'h00, 0, 4, 1);
    step(0, 6'h08, 6'h00, 0, 6'h08, 1, 4, 1);
    step(1, 6'h08, 6'h00, 0, 6'h00, 0, 4, 0);
    step(1, 6'h08, 6'h00, 0, 6'h00, 0, 4, 0);
    step(0, 6'h08, 6'h00, 0, 6'h00, 0, 4, 0);
    step(0, 6'h08, 6'h08, 0, 6'h08, 1, 4, 0);
    step(0, 6'h00, 6'h00, 0, 6'h00, 0, 3, 0);

    // Drain the scoreboard within a bounded number of cycles
    for (int w = 0; w < 5; w++) begin
      if (exp_q.size() == 0) break;
      @(posedge CLK);
    end
    @(posedge CLK);
    checks++;
    if (exp_q.size() == 0) passes++;
    else $display("FAIL drain: got %0d pending expected 0", exp_q.size());

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
